// File: rtl/beam_select_if.sv
// Beam selector bus: sorter index table and full beam vectors in,
// reduced-dimension gathered vectors and status out.
`timescale 1ns/1ps
interface beam_select_if #(
  parameter int IW   = 32,
  parameter int COL  = 64,
  parameter int NSEL = 16,
  parameter int CW   = 12
);
  logic [NSEL-1:0][7:0]    i_beam_index;
  logic                    i_idx_valid;
  logic [COL-1:0][IW-1:0]  i_data;
  logic                    i_rvalid;
  logic                    i_sop;
  logic                    i_eop;

  logic [NSEL-1:0][IW-1:0] o_data;
  logic                    o_tvalid;
  logic                    o_sop;
  logic                    o_eop;
  logic [CW-1:0]           o_re_cnt;
  logic [NSEL-1:0][7:0]    o_beam_index;
  logic                    o_idx_err;
  logic                    o_frame_err;

  modport slave (
    input  i_beam_index, i_idx_valid, i_data, i_rvalid, i_sop, i_eop,
    output o_data, o_tvalid, o_sop, o_eop, o_re_cnt, o_beam_index,
           o_idx_err, o_frame_err
  );

  modport master (
    output i_beam_index, i_idx_valid, i_data, i_rvalid, i_sop, i_eop,
    input  o_data, o_tvalid, o_sop, o_eop, o_re_cnt, o_beam_index,
           o_idx_err, o_frame_err
  );
endinterface

// File: rtl/beam_select.sv
// Applies the sorter's top-NSEL beam table at symbol boundaries and gathers
// the selected beams of each full COL-beam vector into an NSEL-lane output.
`timescale 1ns/1ps
module beam_select #(
  parameter int IW   = 32,
  parameter int COL  = 64,
  parameter int NSEL = 16,
  parameter int CW   = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  beam_select_if.slave  bus
);

  localparam int AW = (COL > 1) ? $clog2(COL) : 1;

  typedef enum logic [1:0] {NO_TAB, IDLE, IN_SYM} state_t;

  state_t                  state_q, state_d;
  logic [NSEL-1:0][7:0]    shadow_q, active_q, sel_tab;
  logic                    pending_q;
  logic                    idx_err_q;
  logic                    frame_err_d, frame_err_q;
  logic                    sop_acc, eop_acc, load, gather;
  logic [CW-1:0]           cnt_q, cnt_p0, cnt_p1, cnt_p2;
  logic [NSEL-1:0][IW-1:0] mux_p0, data_p1, data_p2;
  logic                    vld_p1, sop_p1, eop_p1;
  logic                    vld_p2, sop_p2, eop_p2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic idx_ok(input logic [7:0] idx);
    return {24'd0, idx} < 32'(COL);
  endfunction

  function automatic logic table_bad(input logic [NSEL-1:0][7:0] tab);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NSEL; k++) bad = bad | ~idx_ok(tab[k]);
    return bad;
  endfunction

  assign sop_acc = bus.i_rvalid & bus.i_sop;
  assign eop_acc = bus.i_rvalid & bus.i_eop;

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    gather      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      NO_TAB: begin
        if (sop_acc && pending_q) begin
          load   = 1'b1;
          gather = 1'b1;
        end
      end
      IDLE: begin
        if (sop_acc) begin
          load   = pending_q;
          gather = 1'b1;
        end else if (bus.i_rvalid) begin
          frame_err_d = 1'b1;
        end
      end
      IN_SYM: begin
        if (bus.i_rvalid) begin
          gather      = 1'b1;
          load        = sop_acc & pending_q;
          frame_err_d = sop_acc;
        end
      end
      default: state_d = NO_TAB;
    endcase
    if (gather) state_d = eop_acc ? IDLE : IN_SYM;
  end

  // The beat that loads a table is gathered with that new table.
  assign sel_tab = load ? shadow_q : active_q;
  assign cnt_p0  = sop_acc ? '0 : sat_inc(cnt_q);

  always_comb begin
    for (int k = 0; k < NSEL; k++) begin
      mux_p0[k] = '0;
      if (idx_ok(sel_tab[k])) mux_p0[k] = bus.i_data[sel_tab[k][AW-1:0]];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= NO_TAB;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      idx_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
      vld_p1      <= 1'b0;
      sop_p1      <= 1'b0;
      eop_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      sop_p2      <= 1'b0;
      eop_p2      <= 1'b0;
      data_p2     <= '0;
      cnt_p2      <= '0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      if (bus.i_idx_valid) begin
        shadow_q  <= bus.i_beam_index;
        pending_q <= 1'b1;
      end else if (load) begin
        pending_q <= 1'b0;
      end
      if (load) begin
        active_q  <= shadow_q;
        idx_err_q <= table_bad(shadow_q);
      end
      if (gather) cnt_q <= cnt_p0;
      // p0 -> p1: gathered beat framing
      vld_p1 <= gather;
      sop_p1 <= gather & bus.i_sop;
      eop_p1 <= gather & bus.i_eop;
      // p1 -> p2: output register, zeroed when no beat is present
      vld_p2  <= vld_p1;
      sop_p2  <= vld_p1 & sop_p1;
      eop_p2  <= vld_p1 & eop_p1;
      data_p2 <= vld_p1 ? data_p1 : '0;
      cnt_p2  <= vld_p1 ? cnt_p1 : '0;
    end
  end

  // p0 -> p1: lane mux result, qualified downstream by vld_p1
  always_ff @(posedge i_clk) begin
    if (gather) begin
      data_p1 <= mux_p0;
      cnt_p1  <= cnt_p0;
    end
  end

  assign bus.o_data       = data_p2;
  assign bus.o_tvalid     = vld_p2;
  assign bus.o_sop        = sop_p2;
  assign bus.o_eop        = eop_p2;
  assign bus.o_re_cnt     = cnt_p2;
  assign bus.o_beam_index = active_q;
  assign bus.o_idx_err    = idx_err_q;
  assign bus.o_frame_err  = frame_err_q;

endmodule

// File: doc/beam_select.md
Name: beam_select

Overview:
- Consumer of the beam sort result.
- Holds the top-NSEL beam index table produced by the beam sorter. Applies it at symbol boundaries to a stream of full COL-beam sample vectors.
- Gathers the NSEL selected beams per beat into a reduced-dimension output vector.
- Sits between the beam-domain transform and the downstream reduced-dimension PUSCH processing.

Parameters:
- IW, 32, bit width of one beam sample.
- COL, 64, number of beams per input vector (valid index range 0..COL-1).
- NSEL, 16, number of selected beams per output vector.
- CW, 12, width of the within-symbol beat counter.

Ports:
- i_clk  input  1  clock, all logic rising-edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_beam_index  input  NSEL x 8  beam index table from sorter; entry 0 is the highest-priority beam.
- i_idx_valid  input  1  one-cycle strobe; i_beam_index valid.
- i_data  input  COL x IW  full beam sample vector.
- i_rvalid  input  1  i_data beat valid.
- i_sop  input  1  first beat of a symbol; qualified by i_rvalid.
- i_eop  input  1  last beat of a symbol; qualified by i_rvalid.
- o_data  output  NSEL x IW  lane k = i_data[active_index[k]].
- o_tvalid  output  1  o_data valid.
- o_sop, o_eop  output  1 each  delayed i_sop/i_eop, aligned with o_tvalid.
- o_re_cnt  output  CW  beat number within symbol, aligned with o_data.
- o_beam_index  output  NSEL x 8  active table in use.
- o_idx_err  output  1  sticky; an active index is >= COL.
- o_frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
Reset:
- All outputs, tables and counters clear to 0.
- The pending flag clears and the FSM enters NO_TAB.

Table handling:
- i_idx_valid writes the shadow table and sets pending.
- An accepted sop (i_rvalid & i_sop) with pending set copies shadow to active, clears pending and clears o_idx_err.
- o_idx_err sets if any copied entry is >= COL.
- If i_idx_valid coincides with that sop, the sop uses the old shadow. The new value is written to shadow and pending stays set.
- The active table never changes mid-symbol.

FSM:
- NO_TAB: no active table. All beats are dropped with no output. An accepted sop with pending set loads the table and goes to IN_SYM.
- IDLE: a table is active and no symbol is open. Beats without sop are dropped and pulse o_frame_err. An accepted sop goes to IN_SYM, with a table load if pending is set.
- IN_SYM: every valid beat is gathered. An accepted eop (including sop&eop on the same beat) goes to IDLE.
- A sop while in IN_SYM restarts the symbol: the table is loaded if pending is set, the counter is reset, o_frame_err pulses, and the beat is still output.

Gather pipeline:
- Fixed 2-cycle latency from an accepted beat to o_tvalid. Stage 1 registers the per-lane mux result; stage 2 is the output register.
- No backpressure; there is one output beat per accepted gathered beat, with no bubbles inserted.
- A lane whose index is >= COL outputs 0. Duplicate indices are legal and replicate the same beam.
- When o_tvalid=0, o_data, o_sop and o_eop hold 0.

o_re_cnt:
- 0 on the sop beat, +1 per gathered beat.
- Saturates at 2^CW-1.

Reset mid-operation:
- Asynchronous clear.
- In-flight pipeline beats are discarded; no partial output after reset deasserts.

Test Plan:
- Load table {63,0,5,...,15}, then a 4-beat symbol with i_data[j]=j+100*beat. Required: o_tvalid 2 cycles after each beat; lane0=63+100*beat, lane1=0+100*beat; o_re_cnt 0..3; o_sop on the first output beat and o_eop on the last.
- Data before any table: 3 beats with sop/eop and no i_idx_valid. Required: o_tvalid stays 0; o_frame_err 0 in NO_TAB.
- Table update mid-symbol: new table strobed on beat 2 of 5. Required: beats 2-4 still use the old table; the next symbol's sop uses the new table.
- i_idx_valid on the same cycle as sop. Required: that symbol uses the previous shadow; the following symbol uses the new table.
- Index 70 in lane 3 (COL=64). Required: lane 3 outputs 0 and o_idx_err=1 until the next valid table load, which clears it.
- Framing errors: a beat without sop in IDLE, and a sop inside IN_SYM. Required: one o_frame_err pulse for each. The first beat is dropped; the second beat is output with o_re_cnt=0.
- Assert i_reset_n=0 between two beats mid-symbol. Required: all outputs 0 immediately; no stale beat after release; FSM in NO_TAB.
